hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning consecutive memory-stall cycles before error; legal range is TIMEOUT >= 2.
REQ-002 SHALL have port clk_i  in  1  the single clock.
REQ-003 SHALL have port reset_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports rs1d_i, rs2d_i  in  5 each  source registers in ID.
REQ-005 SHALL have ports rs1e_i, rs2e_i, rde_i  in  5 each  source and destination registers in EX.
REQ-006 SHALL have port resultsrce_i  in  2  EX result source; 2'b01 means load.
REQ-007 SHALL have ports rdm_i, rdw_i  in  5 each, and regwritem_i, regwritew_i  in  1 each  MEM and WB destination and write enable.
REQ-008 SHALL have port pcsrce_i  in  1  branch taken or jump resolved in EX.
REQ-009 SHALL have ports memreqm_i, dmem_ready_i  in  1 each  MEM-stage data access and memory ready.
REQ-010 SHALL have ports stallf_o, stalld_o, stalle_o, stallm_o  out  1 each  stage holds.
REQ-011 SHALL have ports flushd_o, flushe_o, flushw_o  out  1 each  bubble insertion into IF/ID, ID/EX and MEM/WB.
REQ-012 SHALL have ports forwardae_o, forwardbe_o  out  2 each  EX operand select: 00 register file, 01 WB, 10 MEM.
REQ-013 SHALL have port error_o  out  1  sticky memory timeout.
REQ-014 SHALL have ports stall_cnt_o, flush_cnt_o  out  32 each  performance counters.

Function
REQ-015 SHALL compute forwardae_o as 10 when regwritem_i is high, rdm_i!=0 and rdm_i==rs1e_i; otherwise 01 when regwritew_i is high, rdw_i!=0 and rdw_i==rs1e_i; otherwise 00. MEM SHALL win when both match.
REQ-016 SHALL compute forwardbe_o as in REQ-015, using rs2e_i in place of rs1e_i.
REQ-017 SHALL define lwstall = (resultsrce_i==01) and rde_i!=0 and (rde_i==rs1d_i or rde_i==rs2d_i).
REQ-018 SHALL define memstall = memreqm_i and not dmem_ready_i.
REQ-019 SHALL implement a state machine with states RUN, MEM_WAIT and ERROR, and a wait counter.
REQ-020 SHALL make all stall, flush and forward outputs combinational in the same cycle as their inputs.
REQ-021 In RUN or MEM_WAIT with memstall high, SHALL drive stallf, stalld, stalle, stallm and flushw high, and flushd and flushe low. Memstall SHALL take priority over lwstall and pcsrce_i.
REQ-022 Otherwise, SHALL drive stallf = stalld = lwstall, flushe = lwstall or pcsrce_i, flushd = pcsrce_i, and stalle, stallm and flushw low.
REQ-023 When a load-use hazard and a taken branch occur together, SHALL drive stallf, stalld, flushd and flushe all high.
REQ-024 In ERROR, SHALL drive all four stalls high and all three flushes low, regardless of inputs.
REQ-025 In RUN with memstall high, SHALL move to MEM_WAIT and set the wait counter to 1.
REQ-026 In MEM_WAIT with memstall high and wait counter == TIMEOUT-1, SHALL move to ERROR. With memstall high otherwise, SHALL stay in MEM_WAIT and increment the wait counter. With memstall low, SHALL return to RUN and clear the wait counter.
REQ-027 SHALL therefore make ERROR first visible in the cycle after the TIMEOUT-th consecutive memstall cycle.
REQ-028 SHALL leave ERROR only on reset.
REQ-029 SHALL drive error_o high exactly when the state is ERROR.
REQ-030 SHALL increment stall_cnt_o at each edge where stallf_o was high, and flush_cnt_o at each edge where flushd_o or flushe_o was high.
REQ-031 Both counters SHALL wrap from 0xFFFFFFFF to 0 without saturating.

Reset
REQ-032 While reset_i is high, SHALL force all stall, flush and forward outputs to 0.
REQ-033 At a clock edge with reset_i high, SHALL set the state to RUN, clear the wait counter and both counters, and clear error_o.
REQ-034 Reset asserted during MEM_WAIT or ERROR SHALL take precedence over all other inputs.

Structure
REQ-035 SHALL place the following in a shared package hazard_pkg: the state enum, the forward encodings FWD_RF/FWD_WB/FWD_MEM, the constant RESULT_LOAD=2'b01, and the default TIMEOUT.
REQ-036 SHALL instantiate one combinational sub-module, fwd_sel, once per EX operand.

Verification
REQ-037 Test forwarding: rs1e=5, rdm=5, regwritem=1, rdw=5, regwritew=1 -> forwardae=10. Then rdm=0 -> forwardae=01. Then regwritew=0 -> forwardae=00.
REQ-038 Test load-use: resultsrce=01, rde=7, rs2d=7 -> stallf=stalld=flushe=1, flushd=0. Then rde=0 -> all four low.
REQ-039 Test branch: pcsrce=1 with no hazard -> flushd=flushe=1. One cycle later flush_cnt_o=1 and stall_cnt_o=0.
REQ-040 Test memory wait: memreqm=1 with dmem_ready=0 for 3 cycles, then ready=1 -> stallf/d/e/m and flushw high for exactly 3 cycles, then state RUN, stall_cnt_o=3.
REQ-041 Test memory wait with a concurrent branch: as REQ-040 with pcsrce=1 during the wait -> flushd=flushe=0 throughout the wait.
REQ-042 Test timeout: TIMEOUT=16 with memstall held 16 cycles -> error_o=1 on cycle 17, all stalls high, remaining so after memstall drops. Then one reset cycle -> error_o=0, counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding mux select for one EX operand; the younger MEM result beats WB.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rdm_i,
  input  logic [4:0] rdw_i,
  input  logic       regwritem_i,
  input  logic       regwritew_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (regwritem_i && (rdm_i != 5'd0) && (rdm_i == rs_i))
      fwd_o = FWD_MEM;
    else if (regwritew_i && (rdw_i != 5'd0) && (rdw_i == rs_i))
      fwd_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush, memory-wait
// stall with a sticky timeout, and stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  rs1d_i,
  input  logic [4:0]  rs2d_i,
  input  logic [4:0]  rs1e_i,
  input  logic [4:0]  rs2e_i,
  input  logic [4:0]  rde_i,
  input  logic [1:0]  resultsrce_i,
  input  logic [4:0]  rdm_i,
  input  logic [4:0]  rdw_i,
  input  logic        regwritem_i,
  input  logic        regwritew_i,
  input  logic        pcsrce_i,
  input  logic        memreqm_i,
  input  logic        dmem_ready_i,
  output logic        stallf_o,
  output logic        stalld_o,
  output logic        stalle_o,
  output logic        stallm_o,
  output logic        flushd_o,
  output logic        flushe_o,
  output logic        flushw_o,
  output logic [1:0]  forwardae_o,
  output logic [1:0]  forwardbe_o,
  output logic        error_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic [31:0]   flush_cnt_q, flush_cnt_d;
  logic [1:0]    fwd_a, fwd_b;
  logic          lwstall, memstall;

  fwd_sel u_fwd_a (
    .rs_i        (rs1e_i),
    .rdm_i       (rdm_i),
    .rdw_i       (rdw_i),
    .regwritem_i (regwritem_i),
    .regwritew_i (regwritew_i),
    .fwd_o       (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs_i        (rs2e_i),
    .rdm_i       (rdm_i),
    .rdw_i       (rdw_i),
    .regwritem_i (regwritem_i),
    .regwritew_i (regwritew_i),
    .fwd_o       (fwd_b)
  );

  assign lwstall  = (resultsrce_i == RESULT_LOAD) && (rde_i != 5'd0) &&
                    ((rde_i == rs1d_i) || (rde_i == rs2d_i));
  assign memstall = memreqm_i && !dmem_ready_i;

  // Memory wait outranks load-use and branch: the whole pipe freezes and
  // WB gets a bubble, so a pending redirect is simply replayed afterwards.
  always_comb begin
    stallf_o    = 1'b0;
    stalld_o    = 1'b0;
    stalle_o    = 1'b0;
    stallm_o    = 1'b0;
    flushd_o    = 1'b0;
    flushe_o    = 1'b0;
    flushw_o    = 1'b0;
    forwardae_o = FWD_RF;
    forwardbe_o = FWD_RF;
    if (!reset_i) begin
      forwardae_o = fwd_a;
      forwardbe_o = fwd_b;
      if (state_q == ST_ERROR) begin
        stallf_o = 1'b1;
        stalld_o = 1'b1;
        stalle_o = 1'b1;
        stallm_o = 1'b1;
      end else if (memstall) begin
        stallf_o = 1'b1;
        stalld_o = 1'b1;
        stalle_o = 1'b1;
        stallm_o = 1'b1;
        flushw_o = 1'b1;
      end else begin
        stallf_o = lwstall;
        stalld_o = lwstall;
        flushe_o = lwstall || pcsrce_i;
        flushd_o = pcsrce_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_RUN: begin
        if (memstall) begin
          state_d = ST_MEM_WAIT;
          wait_d  = CW'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!memstall) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  assign stall_cnt_d = stall_cnt_q + 32'(stallf_o);
  assign flush_cnt_d = flush_cnt_q + 32'(flushd_o || flushe_o);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign error_o     = (state_q == ST_ERROR);
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, memory wait and timeout.
module tb_hazard_ctrl;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [4:0]  rs1d_i, rs2d_i, rs1e_i, rs2e_i, rde_i, rdm_i, rdw_i;
  logic [1:0]  resultsrce_i;
  logic        regwritem_i, regwritew_i, pcsrce_i, memreqm_i, dmem_ready_i;
  logic        stallf_o, stalld_o, stalle_o, stallm_o;
  logic        flushd_o, flushe_o, flushw_o;
  logic [1:0]  forwardae_o, forwardbe_o;
  logic        error_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.TIMEOUT(16)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rs1d_i       (rs1d_i),
    .rs2d_i       (rs2d_i),
    .rs1e_i       (rs1e_i),
    .rs2e_i       (rs2e_i),
    .rde_i        (rde_i),
    .resultsrce_i (resultsrce_i),
    .rdm_i        (rdm_i),
    .rdw_i        (rdw_i),
    .regwritem_i  (regwritem_i),
    .regwritew_i  (regwritew_i),
    .pcsrce_i     (pcsrce_i),
    .memreqm_i    (memreqm_i),
    .dmem_ready_i (dmem_ready_i),
    .stallf_o     (stallf_o),
    .stalld_o     (stalld_o),
    .stalle_o     (stalle_o),
    .stallm_o     (stallm_o),
    .flushd_o     (flushd_o),
    .flushe_o     (flushe_o),
    .flushw_o     (flushw_o),
    .forwardae_o  (forwardae_o),
    .forwardbe_o  (forwardbe_o),
    .error_o      (error_o),
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {stallf,stalld,stalle,stallm,flushd,flushe,flushw}
  function automatic logic [6:0] ctl();
    return {stallf_o, stalld_o, stalle_o, stallm_o, flushd_o, flushe_o, flushw_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    rs1d_i = 0; rs2d_i = 0; rs1e_i = 0; rs2e_i = 0; rde_i = 0;
    rdm_i = 0; rdw_i = 0; resultsrce_i = 2'b00;
    regwritem_i = 0; regwritew_i = 0; pcsrce_i = 0;
    memreqm_i = 0; dmem_ready_i = 1;
  endtask

  initial begin
    clear_inputs();
    // reset with hazards present: outputs must still read zero
    reset_i = 1; pcsrce_i = 1; memreqm_i = 1; dmem_ready_i = 0;
    rs1e_i = 3; rdm_i = 3; regwritem_i = 1;
    #1;
    check("rst_ctl", 32'(ctl()), 32'h0);
    check("rst_fwda", 32'(forwardae_o), 32'h0);
    tick(); tick();
    check("rst_err", 32'(error_o), 32'h0);
    check("rst_scnt", stall_cnt_o, 32'h0);
    check("rst_fcnt", flush_cnt_o, 32'h0);
    clear_inputs();
    reset_i = 0;
    tick();

    // forwarding priority (no edges inside, counters unaffected)
    rs1e_i = 5; rdm_i = 5; regwritem_i = 1; rdw_i = 5; regwritew_i = 1; #1;
    check("fwd_mem", 32'(forwardae_o), 32'h2);
    rdm_i = 0; #1;
    check("fwd_wb", 32'(forwardae_o), 32'h1);
    regwritew_i = 0; #1;
    check("fwd_rf", 32'(forwardae_o), 32'h0);
    rs2e_i = 9; rdm_i = 9; rdw_i = 9; regwritem_i = 1; regwritew_i = 1; #1;
    check("fwdb_mem", 32'(forwardbe_o), 32'h2);
    check("fwda_rf2", 32'(forwardae_o), 32'h0);
    regwritem_i = 0; #1;
    check("fwdb_wb", 32'(forwardbe_o), 32'h1);
    clear_inputs();

    // load-use, then with concurrent branch
    tick();
    resultsrce_i = 2'b01; rde_i = 7; rs2d_i = 7; #1;
    check("lu_ctl", 32'(ctl()), 32'b1100010);
    pcsrce_i = 1; #1;
    check("lu_br_ctl", 32'(ctl()), 32'b1100110);
    pcsrce_i = 0; rde_i = 0; #1;
    check("lu_off_ctl", 32'(ctl()), 32'b0000000);
    clear_inputs();

    // branch flush, counted at the next edge
    tick();
    pcsrce_i = 1; #1;
    check("br_ctl", 32'(ctl()), 32'b0000110);
    tick();
    pcsrce_i = 0; #1;
    check("br_fcnt", flush_cnt_o, 32'd1);
    check("br_scnt", stall_cnt_o, 32'd0);

    // memory wait of 3 cycles
    memreqm_i = 1; dmem_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_ctl", 32'(ctl()), 32'b1111001);
      tick();
    end
    dmem_ready_i = 1; #1;
    check("mw_rel_ctl", 32'(ctl()), 32'b0000000);
    check("mw_scnt", stall_cnt_o, 32'd3);
    check("mw_err", 32'(error_o), 32'h0);
    tick();

    // memory wait with a concurrent branch: flushes held off
    memreqm_i = 1; dmem_ready_i = 0; pcsrce_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mwb_ctl", 32'(ctl()), 32'b1111001);
      tick();
    end
    dmem_ready_i = 1; pcsrce_i = 0; #1;
    check("mwb_rel_ctl", 32'(ctl()), 32'b0000000);
    check("mwb_scnt", stall_cnt_o, 32'd6);
    check("mwb_fcnt", flush_cnt_o, 32'd1);
    tick();

    // timeout: 16 stalled edges, error visible after the 16th
    memreqm_i = 1; dmem_ready_i = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("to_pre_err", 32'(error_o), 32'h0);
      tick();
    end
    #1;
    check("to_err", 32'(error_o), 32'h1);
    check("to_ctl", 32'(ctl()), 32'b1111000);
    check("to_scnt", stall_cnt_o, 32'd22);
    memreqm_i = 0; dmem_ready_i = 1; pcsrce_i = 1;
    resultsrce_i = 2'b01; rde_i = 4; rs1d_i = 4; #1;
    check("to_hold_ctl", 32'(ctl()), 32'b1111000);
    tick();
    check("to_hold_err", 32'(error_o), 32'h1);
    check("to_hold_scnt", stall_cnt_o, 32'd23);
    check("to_hold_fcnt", flush_cnt_o, 32'd1);

    // one reset cycle clears everything
    reset_i = 1; #1;
    check("rst2_ctl", 32'(ctl()), 32'h0);
    tick();
    reset_i = 0;
    clear_inputs();
    #1;
    check("rst2_err", 32'(error_o), 32'h0);
    check("rst2_scnt", stall_cnt_o, 32'h0);
    check("rst2_fcnt", flush_cnt_o, 32'h0);
    check("rst2_ctl_run", 32'(ctl()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
